ob_table: RTL and testbench

- Parametrised, sorted order-book side table: holds up to N table_t entries ordered by price priority, with the winning entry always at slot 0.
- One instance serves the bid side and another the ask side; direction is set by parameter.
- Sits behind the order-book command decoder. Takes insert/pop commands over a valid/ready handshake, returns one response per command, and exposes the current top-of-book continuously.

---
 rtl/bcd_pkg.sv | 7 +
 rtl/ob_pkg.sv | 38 +++
 rtl/ob_table_pos.sv | 45 ++++
 rtl/ob_table.sv | 167 ++++++++++++++++
 tb/tb_ob_table.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// BCD price type shared by the order-book blocks; four packed BCD digits.
package bcd_pkg;
  typedef logic [15:0] price_t;

  localparam price_t PRICE_MIN = 16'h0000;
  localparam price_t PRICE_MAX = 16'h9999;
endpackage

// File: rtl/ob_pkg.sv
// Order-book types: table entry, table command ops, response status codes.
package ob_pkg;
  import bcd_pkg::*;

  localparam int UID_W = 16;
  localparam int QTY_W = 16;

  typedef logic [UID_W-1:0] uid_t;

  typedef struct packed {
    uid_t             uid;
    price_t           price;
    logic [QTY_W-1:0] qty;
  } table_t;

  typedef enum logic [1:0] {
    Tbl_Nop    = 2'b00,
    Tbl_Insert = 2'b01,
    Tbl_PopTop = 2'b10,
    Tbl_Cancel = 2'b11
  } tbl_op_t;

  typedef enum logic [2:0] {
    S_Okay               = 3'b000,
    S_ErrRejectTableFull = 3'b001,
    S_ErrTableEmpty      = 3'b010,
    S_ErrUidNotFound     = 3'b011,
    S_ErrUnsupported     = 3'b100
  } status_t;

  // Empty slots hold the worst price for the side so they never win a compare.
  localparam table_t TABLE_BID_INIT = {{UID_W{1'b0}}, PRICE_MIN, {QTY_W{1'b0}}};
  localparam table_t TABLE_ASK_INIT = {{UID_W{1'b0}}, PRICE_MAX, {QTY_W{1'b0}}};

  function automatic table_t side_init(input bit is_bid);
    return is_bid ? TABLE_BID_INIT : TABLE_ASK_INIT;
  endfunction
endpackage

// File: rtl/ob_table_pos.sv
// Combinational slot search: one-hot insert position and (OB_TABLE_CANCEL_EN)
// one-hot first uid match.
module ob_table_pos
  import ob_pkg::*;
#(
  parameter int N      = 16,
  parameter bit IS_BID = 1'b1
) (
  input  bcd_pkg::price_t prices [N],
  input  logic [N-1:0]    valid,
  input  bcd_pkg::price_t price,
  output logic [N-1:0]    ins_oh
`ifdef OB_TABLE_CANCEL_EN
  ,
  input  uid_t            uids [N],
  input  uid_t            uid,
  output logic [N-1:0]    uid_oh
`endif
);

  logic [N-1:0] ins_hit;

  // Strict compare keeps equal prices ahead of the newcomer (time priority).
  always_comb begin
    ins_hit = '0;
    for (int i = 0; i < N; i++) begin
      if (IS_BID) ins_hit[i] = ~valid[i] | (prices[i] < price);
      else        ins_hit[i] = ~valid[i] | (prices[i] > price);
    end
  end

  assign ins_oh = ins_hit & (~ins_hit + N'(1));

`ifdef OB_TABLE_CANCEL_EN
  logic [N-1:0] uid_hit;

  always_comb begin
    uid_hit = '0;
    for (int i = 0; i < N; i++) uid_hit[i] = valid[i] & (uids[i] == uid);
  end

  assign uid_oh = uid_hit & (~uid_hit + N'(1));
`endif

endmodule

// File: rtl/ob_table.sv
// Sorted order-book side table, best entry in slot 0, one response per command.
// Cancel-by-uid is built only when OB_TABLE_CANCEL_EN is defined.
module ob_table
  import ob_pkg::*;
#(
  parameter int N      = 16,
  parameter bit IS_BID = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_vld,
  input  tbl_op_t                  cmd_op,
  input  table_t                   cmd_entry,
  output logic                     cmd_rdy,
  output logic                     rsp_vld,
  output status_t                  rsp_status,
  output table_t                   rsp_entry,
  input  logic                     rsp_rdy,
  output logic                     top_vld,
  output table_t                   top,
  output logic [$clog2(N+1)-1:0]   count
);

  localparam int     CW   = $clog2(N+1);
  localparam table_t INIT = side_init(IS_BID);

  table_t          slots [N];
  logic [N-1:0]    valid;
  logic [CW-1:0]   cnt;

  table_t          up [N];
  table_t          down [N];
  bcd_pkg::price_t prices [N];
  logic [N-1:0]    ins_oh;

  table_t          nxt_slots [N];
  logic [N-1:0]    nxt_valid;
  logic [CW-1:0]   nxt_cnt;
  status_t         nxt_status;
  table_t          nxt_entry;
  logic            shift_on;
  logic            accept;

  always_comb begin
    for (int i = 0; i < N; i++) prices[i] = slots[i].price;
  end

  // Pre-shifted views of the table: up removes a slot, down opens one.
  always_comb begin
    up[N-1] = INIT;
    for (int i = 0; i < N-1; i++) up[i] = slots[i+1];
  end

  always_comb begin
    down[0] = INIT;
    for (int i = 1; i < N; i++) down[i] = slots[i-1];
  end

`ifdef OB_TABLE_CANCEL_EN
  uid_t         uids [N];
  logic [N-1:0] uid_oh;

  always_comb begin
    for (int i = 0; i < N; i++) uids[i] = slots[i].uid;
  end
`endif

  ob_table_pos #(
    .N      (N),
    .IS_BID (IS_BID)
  ) u_pos (
    .prices (prices),
    .valid  (valid),
    .price  (cmd_entry.price),
    .ins_oh (ins_oh)
`ifdef OB_TABLE_CANCEL_EN
    ,
    .uids   (uids),
    .uid    (cmd_entry.uid),
    .uid_oh (uid_oh)
`endif
  );

  always_comb begin
    nxt_slots  = slots;
    nxt_valid  = valid;
    nxt_cnt    = cnt;
    nxt_status = S_Okay;
    nxt_entry  = cmd_entry;
    shift_on   = 1'b0;
    case (cmd_op)
      Tbl_Insert: begin
        if (cnt == CW'(N)) begin
          nxt_status = S_ErrRejectTableFull;
        end else begin
          for (int i = 0; i < N; i++) begin
            shift_on = shift_on | ins_oh[i];
            if (ins_oh[i])     nxt_slots[i] = cmd_entry;
            else if (shift_on) nxt_slots[i] = down[i];
          end
          nxt_valid = {valid[N-2:0], 1'b1};
          nxt_cnt   = cnt + CW'(1);
        end
      end
      Tbl_PopTop: begin
        if (!valid[0]) begin
          nxt_status = S_ErrTableEmpty;
          nxt_entry  = INIT;
        end else begin
          nxt_slots = up;
          nxt_valid = valid >> 1;
          nxt_cnt   = cnt - CW'(1);
          nxt_entry = slots[0];
        end
      end
      Tbl_Cancel: begin
`ifdef OB_TABLE_CANCEL_EN
        if (uid_oh == '0) begin
          nxt_status = S_ErrUidNotFound;
        end else begin
          for (int i = 0; i < N; i++) begin
            shift_on = shift_on | uid_oh[i];
            if (shift_on)  nxt_slots[i] = up[i];
            if (uid_oh[i]) nxt_entry    = slots[i];
          end
          nxt_valid = valid >> 1;
          nxt_cnt   = cnt - CW'(1);
        end
`else
        nxt_status = S_ErrUnsupported;
`endif
      end
      default: ;
    endcase
  end

  assign cmd_rdy = ~rsp_vld | rsp_rdy;
  assign accept  = cmd_vld & cmd_rdy;
  assign top     = slots[0];
  assign top_vld = valid[0];
  assign count   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) slots[i] <= INIT;
      valid      <= '0;
      cnt        <= '0;
      rsp_vld    <= 1'b0;
      rsp_status <= S_Okay;
      rsp_entry  <= '0;
    end else if (accept) begin
      slots <= nxt_slots;
      valid <= nxt_valid;
      cnt   <= nxt_cnt;
      if (cmd_op != Tbl_Nop) begin
        rsp_vld    <= 1'b1;
        rsp_status <= nxt_status;
        rsp_entry  <= nxt_entry;
      end else if (rsp_rdy) begin
        rsp_vld <= 1'b0;
      end
    end else if (rsp_rdy) begin
      rsp_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ob_table.sv
// Bench for ob_table: a bid and an ask instance (N=4) share one command bus and
// are compared against an array-based price/time-priority model.
module tb_ob_table;
  import ob_pkg::*;

  localparam int NT  = 4;
  localparam int CWT = $clog2(NT+1);

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    cmd_vld = 1'b0;
  tbl_op_t cmd_op = Tbl_Nop;
  table_t  cmd_entry = '0;
  logic    rsp_rdy = 1'b1;

  logic           cmd_rdy_b, rsp_vld_b, top_vld_b;
  status_t        rsp_status_b;
  table_t         rsp_entry_b, top_b;
  logic [CWT-1:0] count_b;
  logic           cmd_rdy_a, rsp_vld_a, top_vld_a;
  status_t        rsp_status_a;
  table_t         rsp_entry_a, top_a;
  logic [CWT-1:0] count_a;

  int n_chk = 0;
  int n_pass = 0;

  table_t marr [2][NT];
  int     mcnt [2];

  always #5 clk = ~clk;

  ob_table #(.N(NT), .IS_BID(1'b1)) u_bid (
    .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_op(cmd_op),
    .cmd_entry(cmd_entry), .cmd_rdy(cmd_rdy_b), .rsp_vld(rsp_vld_b),
    .rsp_status(rsp_status_b), .rsp_entry(rsp_entry_b), .rsp_rdy(rsp_rdy),
    .top_vld(top_vld_b), .top(top_b), .count(count_b)
  );

  ob_table #(.N(NT), .IS_BID(1'b0)) u_ask (
    .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_op(cmd_op),
    .cmd_entry(cmd_entry), .cmd_rdy(cmd_rdy_a), .rsp_vld(rsp_vld_a),
    .rsp_status(rsp_status_a), .rsp_entry(rsp_entry_a), .rsp_rdy(rsp_rdy),
    .top_vld(top_vld_a), .top(top_a), .count(count_a)
  );

  function automatic table_t init_of(input int s);
    table_t t;
    t = '0;
    t.price = (s == 1) ? 16'h0000 : 16'h9999;
    return t;
  endfunction

  function automatic table_t mk(input int uid, input logic [15:0] price);
    table_t t;
    t.uid   = 16'(uid);
    t.price = price;
    t.qty   = 16'(uid * 3 + 1);
    return t;
  endfunction

  function automatic logic [15:0] rand_price();
    logic [3:0] hi, mid;
    hi  = 4'($urandom_range(1, 3));
    mid = ($urandom_range(0, 1) != 0) ? 4'h5 : 4'h0;
    return {4'h0, hi, mid, 4'h0};
  endfunction

  // s = 1 bid side (better = higher price), s = 0 ask side (better = lower).
  task automatic model_step(input int s, input tbl_op_t op, input table_t e,
                            output status_t st, output table_t re);
    int  j;
    bit  found;
    st = S_Okay;
    re = e;
    case (op)
      Tbl_Insert: begin
        if (mcnt[s] == NT) begin
          st = S_ErrRejectTableFull;
        end else begin
          j = mcnt[s];
          found = 0;
          for (int k = 0; k < mcnt[s]; k++) begin
            if (!found && ((s == 1) ? (marr[s][k].price < e.price)
                                    : (marr[s][k].price > e.price))) begin
              j = k;
              found = 1;
            end
          end
          for (int k = mcnt[s]; k > j; k--) marr[s][k] = marr[s][k-1];
          marr[s][j] = e;
          mcnt[s]++;
        end
      end
      Tbl_PopTop: begin
        if (mcnt[s] == 0) begin
          st = S_ErrTableEmpty;
          re = init_of(s);
        end else begin
          re = marr[s][0];
          for (int k = 0; k < mcnt[s] - 1; k++) marr[s][k] = marr[s][k+1];
          mcnt[s]--;
        end
      end
      Tbl_Cancel: begin
`ifdef OB_TABLE_CANCEL_EN
        j = -1;
        for (int k = mcnt[s] - 1; k >= 0; k--)
          if (marr[s][k].uid == e.uid) j = k;
        if (j < 0) begin
          st = S_ErrUidNotFound;
        end else begin
          re = marr[s][j];
          for (int k = j; k < mcnt[s] - 1; k++) marr[s][k] = marr[s][k+1];
          mcnt[s]--;
        end
`else
        st = S_ErrUnsupported;
`endif
      end
      default: ;
    endcase
  endtask

  // Drives one command from a negedge, waits for acceptance, checks both sides
  // at the following negedge against the model.
  task automatic issue(input tbl_op_t op, input table_t e);
    status_t xs_b, xs_a;
    table_t  xe_b, xe_a, et_b, et_a;
    int      w;
    model_step(1, op, e, xs_b, xe_b);
    model_step(0, op, e, xs_a, xe_a);
    cmd_vld = 1'b1;
    cmd_op = op;
    cmd_entry = e;
    w = 0;
    while (!cmd_rdy_b && w < 20) begin
      @(posedge clk);
      @(negedge clk);
      w++;
    end
    n_chk++;
    if (!cmd_rdy_b) begin
      $display("FAIL accept_timeout op=%0d cmd_rdy=%0b required=1", op, cmd_rdy_b);
      cmd_vld = 1'b0;
      return;
    end
    n_pass++;
    @(posedge clk);
    @(negedge clk);
    cmd_vld = 1'b0;
    cmd_op = Tbl_Nop;
    et_b = (mcnt[1] > 0) ? marr[1][0] : init_of(1);
    et_a = (mcnt[0] > 0) ? marr[0][0] : init_of(0);
    n_chk += 4;
    if (op == Tbl_Nop) begin
      if (rsp_vld_b !== 1'b0)
        $display("FAIL nop_rsp_bid rsp_vld=%0b required=0", rsp_vld_b);
      else n_pass++;
      if (rsp_vld_a !== 1'b0)
        $display("FAIL nop_rsp_ask rsp_vld=%0b required=0", rsp_vld_a);
      else n_pass++;
    end else begin
      if ({rsp_vld_b, rsp_status_b, rsp_entry_b} !== {1'b1, xs_b, xe_b})
        $display("FAIL rsp_bid op=%0d got vld=%0b st=%0d e=%h required vld=1 st=%0d e=%h",
                 op, rsp_vld_b, rsp_status_b, rsp_entry_b, xs_b, xe_b);
      else n_pass++;
      if ({rsp_vld_a, rsp_status_a, rsp_entry_a} !== {1'b1, xs_a, xe_a})
        $display("FAIL rsp_ask op=%0d got vld=%0b st=%0d e=%h required vld=1 st=%0d e=%h",
                 op, rsp_vld_a, rsp_status_a, rsp_entry_a, xs_a, xe_a);
      else n_pass++;
    end
    if ({count_b, top_vld_b, top_b} !== {CWT'(mcnt[1]), mcnt[1] > 0, et_b})
      $display("FAIL top_bid got cnt=%0d tv=%0b top=%h required cnt=%0d top=%h",
               count_b, top_vld_b, top_b, mcnt[1], et_b);
    else n_pass++;
    if ({count_a, top_vld_a, top_a} !== {CWT'(mcnt[0]), mcnt[0] > 0, et_a})
      $display("FAIL top_ask got cnt=%0d tv=%0b top=%h required cnt=%0d top=%h",
               count_a, top_vld_a, top_a, mcnt[0], et_a);
    else n_pass++;
  endtask

  task automatic drain();
    repeat (NT) issue(Tbl_PopTop, '0);
  endtask

  task automatic test_reset();
    n_chk += 4;
    if ({cmd_rdy_b, rsp_vld_b, rsp_status_b, rsp_entry_b} !== {1'b1, 1'b0, S_Okay, 48'h0})
      $display("FAIL reset_rsp_bid rdy=%0b vld=%0b st=%0d e=%h required 1/0/0/0",
               cmd_rdy_b, rsp_vld_b, rsp_status_b, rsp_entry_b);
    else n_pass++;
    if ({cmd_rdy_a, rsp_vld_a, rsp_status_a, rsp_entry_a} !== {1'b1, 1'b0, S_Okay, 48'h0})
      $display("FAIL reset_rsp_ask rdy=%0b vld=%0b st=%0d e=%h required 1/0/0/0",
               cmd_rdy_a, rsp_vld_a, rsp_status_a, rsp_entry_a);
    else n_pass++;
    if ({count_b, top_vld_b, top_b} !== {CWT'(0), 1'b0, init_of(1)})
      $display("FAIL reset_top_bid cnt=%0d tv=%0b top=%h", count_b, top_vld_b, top_b);
    else n_pass++;
    if ({count_a, top_vld_a, top_a} !== {CWT'(0), 1'b0, init_of(0)})
      $display("FAIL reset_top_ask cnt=%0d tv=%0b top=%h", count_a, top_vld_a, top_a);
    else n_pass++;
  endtask

  task automatic test_sorted_insert();
    issue(Tbl_Insert, mk(1, 16'h0100));
    issue(Tbl_Insert, mk(2, 16'h0300));
    issue(Tbl_Insert, mk(3, 16'h0200));
    n_chk += 2;
    if (top_b.uid !== 16'd2 || count_b !== CWT'(3))
      $display("FAIL bid_top_uid uid=%0d cnt=%0d required uid=2 cnt=3", top_b.uid, count_b);
    else n_pass++;
    if (top_a.uid !== 16'd1)
      $display("FAIL ask_top_uid uid=%0d required 1", top_a.uid);
    else n_pass++;
    drain();
    issue(Tbl_Insert, mk(1, 16'h0150));
    issue(Tbl_Insert, mk(2, 16'h0150));
    issue(Tbl_Insert, mk(3, 16'h0120));
    issue(Tbl_PopTop, '0);
    n_chk++;
    if (rsp_entry_a.uid !== 16'd3)
      $display("FAIL ask_pop1 uid=%0d required 3", rsp_entry_a.uid);
    else n_pass++;
    issue(Tbl_PopTop, '0);
    n_chk++;
    if (rsp_entry_a.uid !== 16'd1)
      $display("FAIL ask_tie uid=%0d required 1", rsp_entry_a.uid);
    else n_pass++;
    drain();
  endtask

  task automatic test_full();
    for (int i = 0; i < NT; i++) issue(Tbl_Insert, mk(i + 1, 16'h0100 + 16'(i) * 16'h0010));
    issue(Tbl_Insert, mk(9, 16'h0500));
    n_chk++;
    if (rsp_status_b !== S_ErrRejectTableFull || rsp_entry_b.uid !== 16'd9 || count_b !== CWT'(NT))
      $display("FAIL full_reject st=%0d uid=%0d cnt=%0d required st=1 uid=9 cnt=%0d",
               rsp_status_b, rsp_entry_b.uid, count_b, NT);
    else n_pass++;
    drain();
  endtask

  task automatic test_empty_pop();
    issue(Tbl_PopTop, '0);
    issue(Tbl_Insert, mk(5, 16'h0250));
    issue(Tbl_PopTop, '0);
    issue(Tbl_PopTop, '0);
    n_chk++;
    if (rsp_status_b !== S_ErrTableEmpty || top_vld_b !== 1'b0)
      $display("FAIL empty_pop st=%0d tv=%0b required st=2 tv=0", rsp_status_b, top_vld_b);
    else n_pass++;
  endtask

  task automatic test_back_to_back_stall();
    status_t sa_b, sa_a, sb_b, sb_a;
    table_t  ea_b, ea_a, eb_b, eb_a;
    table_t  ca, cb;
    @(posedge clk);
    @(negedge clk);
    rsp_rdy = 1'b0;
    ca = mk(21, 16'h0200);
    cb = mk(22, 16'h0250);
    model_step(1, Tbl_Insert, ca, sa_b, ea_b);
    model_step(0, Tbl_Insert, ca, sa_a, ea_a);
    cmd_vld = 1'b1;
    cmd_op = Tbl_Insert;
    cmd_entry = ca;
    @(posedge clk);
    @(negedge clk);
    model_step(1, Tbl_Insert, cb, sb_b, eb_b);
    model_step(0, Tbl_Insert, cb, sb_a, eb_a);
    cmd_entry = cb;
    for (int c = 0; c < 3; c++) begin
      n_chk += 2;
      if ({cmd_rdy_b, rsp_vld_b, rsp_status_b, rsp_entry_b} !== {1'b0, 1'b1, sa_b, ea_b})
        $display("FAIL stall_bid cyc=%0d rdy=%0b vld=%0b e=%h required rdy=0 vld=1 e=%h",
                 c, cmd_rdy_b, rsp_vld_b, rsp_entry_b, ea_b);
      else n_pass++;
      if ({cmd_rdy_a, rsp_vld_a, rsp_entry_a, count_a} !== {1'b0, 1'b1, ea_a, CWT'(1)})
        $display("FAIL stall_ask cyc=%0d rdy=%0b vld=%0b cnt=%0d required rdy=0 vld=1 cnt=1",
                 c, cmd_rdy_a, rsp_vld_a, count_a);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
    end
    rsp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_vld = 1'b0;
    cmd_op = Tbl_Nop;
    n_chk += 2;
    if ({rsp_vld_b, rsp_status_b, rsp_entry_b, count_b} !== {1'b1, sb_b, eb_b, CWT'(mcnt[1])})
      $display("FAIL release_bid vld=%0b e=%h cnt=%0d required e=%h cnt=%0d",
               rsp_vld_b, rsp_entry_b, count_b, eb_b, mcnt[1]);
    else n_pass++;
    if ({rsp_vld_a, rsp_status_a, top_a, count_a} !== {1'b1, sb_a, marr[0][0], CWT'(mcnt[0])})
      $display("FAIL release_ask vld=%0b top=%h cnt=%0d required top=%h cnt=%0d",
               rsp_vld_a, top_a, count_a, marr[0][0], mcnt[0]);
    else n_pass++;
    drain();
  endtask

  task automatic test_cancel();
    issue(Tbl_Insert, mk(1, 16'h0100));
    issue(Tbl_Insert, mk(2, 16'h0300));
    issue(Tbl_Insert, mk(3, 16'h0200));
    issue(Tbl_Cancel, mk(2, 16'h0000));
    n_chk++;
`ifdef OB_TABLE_CANCEL_EN
    if (rsp_status_b !== S_Okay || count_b !== CWT'(2) || rsp_entry_b.price !== 16'h0300)
      $display("FAIL cancel_hit st=%0d cnt=%0d price=%h required st=0 cnt=2 price=0300",
               rsp_status_b, count_b, rsp_entry_b.price);
    else n_pass++;
`else
    if (rsp_status_b !== S_ErrUnsupported || count_b !== CWT'(3))
      $display("FAIL cancel_unsup st=%0d cnt=%0d required st=4 cnt=3", rsp_status_b, count_b);
    else n_pass++;
`endif
    issue(Tbl_Cancel, mk(7, 16'h0000));
    n_chk++;
`ifdef OB_TABLE_CANCEL_EN
    if (rsp_status_a !== S_ErrUidNotFound)
      $display("FAIL cancel_miss st=%0d required 3", rsp_status_a);
    else n_pass++;
`else
    if (rsp_status_a !== S_ErrUnsupported)
      $display("FAIL cancel_miss st=%0d required 4", rsp_status_a);
    else n_pass++;
`endif
    drain();
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      issue(Tbl_Insert, mk($urandom_range(1, 6), rand_price()));
      else if (r < 8) issue(Tbl_PopTop, mk($urandom_range(1, 6), rand_price()));
      else if (r < 9) issue(Tbl_Cancel, mk($urandom_range(1, 6), rand_price()));
      else            issue(Tbl_Nop, mk($urandom_range(1, 6), rand_price()));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid();
    issue(Tbl_Insert, mk(11, 16'h0110));
    issue(Tbl_Insert, mk(12, 16'h0120));
    cmd_vld = 1'b1;
    cmd_op = Tbl_Insert;
    cmd_entry = mk(13, 16'h0130);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    cmd_vld = 1'b0;
    cmd_op = Tbl_Nop;
    n_chk += 2;
    if ({rsp_vld_b, rsp_status_b, rsp_entry_b, count_b, top_vld_b, top_b} !==
        {1'b0, S_Okay, 48'h0, CWT'(0), 1'b0, init_of(1)})
      $display("FAIL midreset_bid vld=%0b e=%h cnt=%0d tv=%0b top=%h required all reset",
               rsp_vld_b, rsp_entry_b, count_b, top_vld_b, top_b);
    else n_pass++;
    if ({rsp_vld_a, rsp_status_a, rsp_entry_a, count_a, top_vld_a, top_a} !==
        {1'b0, S_Okay, 48'h0, CWT'(0), 1'b0, init_of(0)})
      $display("FAIL midreset_ask vld=%0b e=%h cnt=%0d tv=%0b top=%h required all reset",
               rsp_vld_a, rsp_entry_a, count_a, top_vld_a, top_a);
    else n_pass++;
    mcnt[0] = 0;
    mcnt[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(Tbl_Insert, mk(14, 16'h0140));
    issue(Tbl_PopTop, '0);
  endtask

  initial begin
    mcnt[0] = 0;
    mcnt[1] = 0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_sorted_insert();
    test_full();
    test_empty_pop();
    test_back_to_back_stall();
    test_cancel();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
